axi_burst_master: RTL and testbench

AXI_BURST_MASTER -- requirements
Module: axi_burst_master

---
 rtl/axi_burst_master.sv | 196 +++++++++++++++++++
 tb/tb_axi_burst_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// AXI4 single-outstanding burst master: writes an incrementing pattern
// (seed+k) to a burst, reads it back and counts mismatched or errored beats.
// Handshakes: a transfer happens on a rising aclk edge where valid & ready
// are both high; this master raises valid only in the owning state, holds
// every payload field stable until that edge, and raises ready only in the
// state that expects the response.
module axi_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int TXN_ID     = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [7:0]              len,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             err_cnt,
  output logic                    reject,
  output logic [2:0]              fsm_state,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [ID_WIDTH-1:0]     m_axi_rid,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SIZE  = $clog2(BYTES);
  localparam logic [ID_WIDTH-1:0] ID = ID_WIDTH'(TXN_ID);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [DATA_WIDTH-1:0]   seed_q;
  logic [7:0]              beat_q;
  logic [15:0]             err_q;
  logic                    reject_q;

  logic                    misaligned;
  logic [13:0]             end_off;
  logic                    crosses;
  logic                    bad_cmd;
  logic                    last_beat;
  logic [DATA_WIDTH-1:0]   exp_data;
  logic                    b_bad;
  logic                    r_bad;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Command screening: the burst end offset within its 4 KB page must not pass 4096.
  assign misaligned = |base_addr[SIZE-1:0];
  assign end_off    = {2'b00, base_addr[11:0]} + (({6'b0, len} + 14'd1) << SIZE);
  assign crosses    = end_off > 14'd4096;
  assign bad_cmd    = misaligned | crosses;

  assign last_beat  = (beat_q == len_q);
  assign exp_data   = seed_q + DATA_WIDTH'(beat_q);
  assign b_bad      = (m_axi_bresp != 2'b00) | (m_axi_bid != ID);
  assign r_bad      = (m_axi_rdata != exp_data) | (m_axi_rresp != 2'b00) |
                      (m_axi_rid != ID) | (m_axi_rlast != last_beat);

  // Address/payload fields come straight from the latched command so they stay stable.
  assign m_axi_awid    = ID;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;
  assign m_axi_arid    = ID;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;
  assign m_axi_wdata   = exp_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = last_beat;
  assign err_cnt       = err_q;
  assign reject        = reject_q;
  assign fsm_state     = state_q;

  // State register; reset aborts any burst in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and per-state valid/ready/status outputs.
  always_comb begin
    state_d       = state_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    done          = 1'b0;
    busy          = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: if (start) state_d = bad_cmd ? ST_FIN : ST_AW;
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && last_beat) state_d = ST_B;
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = ST_AR;
      end
      ST_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = ST_R;
      end
      ST_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && last_beat) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command latch, beat counter and saturating error counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q   <= '0;
      len_q    <= '0;
      seed_q   <= '0;
      beat_q   <= '0;
      err_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          addr_q   <= base_addr;
          len_q    <= len;
          seed_q   <= seed;
          beat_q   <= '0;
          err_q    <= '0;
          reject_q <= bad_cmd;
        end
        ST_W: if (m_axi_wready) beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
        ST_B: if (m_axi_bvalid && b_bad) err_q <= sat_inc(err_q);
        ST_R: if (m_axi_rvalid) begin
          if (r_bad) err_q <= sat_inc(err_q);
          beat_q <= beat_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a sequential RAM-slave driver.
module tb_axi_burst_master;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic [15:0] base_addr;
  logic [7:0]  len;
  logic [31:0] seed;
  logic        busy, done, reject;
  logic [15:0] err_cnt;
  logic [2:0]  fsm_state;
  logic [7:0]  awid, arid, bid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [int];

  axi_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8), .TXN_ID(0)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .base_addr(base_addr),
    .len(len), .seed(seed), .busy(busy), .done(done), .err_cnt(err_cnt),
    .reject(reject), .fsm_state(fsm_state),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
    .m_axi_arsize(arsize), .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready), .m_axi_rid(rid), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // Clock
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  function automatic logic [31:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic outs_quiet();
    return !(awvalid | wvalid | bready | arvalid | rready | busy | done | reject);
  endfunction

  // Full write/read-back command against the RAM slave; max_dly sets ready/valid gaps.
  task automatic run_cmd(input logic [15:0] b, input logic [7:0] l, input logic [31:0] sd,
                         input int max_dly, input int bad_beat, input logic [1:0] b_resp,
                         input logic [15:0] exp_err, input string tag);
    int d;
    logic [31:0] ev;
    @(negedge aclk);
    start = 1'b1; base_addr = b; len = l; seed = sd;
    @(negedge aclk);
    start = 1'b0; base_addr = '0; len = '0; seed = '0;
    checks++;
    if (awvalid !== 1'b1 || busy !== 1'b1 || wvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s aw_latency: awvalid=%b busy=%b wvalid=%b required 1 1 0", tag, awvalid, busy, wvalid);
    end
    checks++;
    if ({awaddr, awlen, awsize, awburst, awid} !== {b, l, 3'd2, 2'b01, 8'd0}) begin
      errors++;
      $display("FAIL %s aw_fields: addr=%h len=%0d size=%0d burst=%b id=%h required %h %0d 2 01 00",
               tag, awaddr, awlen, awsize, awburst, awid, b, l);
    end
    for (int k = 0; k <= int'(l); k++) exp_q.push_back(sd + 32'(k));
    // AW backpressure, with a start pulse that must be ignored while busy
    d = $urandom_range(0, max_dly);
    for (int i = 0; i < d; i++) begin
      if (i == 0) begin start = 1'b1; base_addr = b ^ 16'h0040; len = l + 8'd1; end
      @(negedge aclk);
      start = 1'b0;
      checks++;
      if (awvalid !== 1'b1 || awaddr !== b || awlen !== l || wvalid !== 1'b0) begin
        errors++;
        $display("FAIL %s aw_hold: awvalid=%b addr=%h len=%0d wvalid=%b required 1 %h %0d 0",
                 tag, awvalid, awaddr, awlen, wvalid, b, l);
      end
    end
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0;
    // W beats
    for (int k = 0; k <= int'(l); k++) begin
      ev = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      d = $urandom_range(0, max_dly);
      for (int i = 0; i <= d; i++) begin
        checks++;
        if (wvalid !== 1'b1 || awvalid !== 1'b0 || wdata !== ev || wlast !== (k == int'(l)) || wstrb !== 4'hF) begin
          errors++;
          $display("FAIL %s w_beat%0d: wvalid=%b awvalid=%b data=%h last=%b strb=%h required 1 0 %h %b f",
                   tag, k, wvalid, awvalid, wdata, wlast, wstrb, ev, k == int'(l));
        end
        if (i < d) @(negedge aclk);
      end
      mem[int'(b) + 4 * k] = wdata;
      wready = 1'b1;
      @(negedge aclk);
      wready = 1'b0;
    end
    // B response
    checks++;
    if (bready !== 1'b1 || wvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s b_ready: bready=%b wvalid=%b required 1 0", tag, bready, wvalid);
    end
    bvalid = 1'b1; bid = 8'd0; bresp = b_resp;
    @(negedge aclk);
    bvalid = 1'b0; bresp = 2'b00;
    // AR
    d = $urandom_range(0, max_dly);
    for (int i = 0; i <= d; i++) begin
      checks++;
      if (arvalid !== 1'b1 || bready !== 1'b0 ||
          {araddr, arlen, arsize, arburst, arid} !== {b, l, 3'd2, 2'b01, 8'd0}) begin
        errors++;
        $display("FAIL %s ar_fields: arvalid=%b bready=%b addr=%h len=%0d size=%0d burst=%b id=%h required 1 0 %h %0d 2 01 00",
                 tag, arvalid, bready, araddr, arlen, arsize, arburst, arid, b, l);
      end
      if (i < d) @(negedge aclk);
    end
    arready = 1'b1;
    @(negedge aclk);
    arready = 1'b0;
    // R beats, with idle gaps that must not advance the beat count
    for (int k = 0; k <= int'(l); k++) begin
      d = $urandom_range(0, max_dly);
      repeat (d) @(negedge aclk);
      checks++;
      if (rready !== 1'b1 || arvalid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s r_ready%0d: rready=%b arvalid=%b done=%b required 1 0 0", tag, k, rready, arvalid, done);
      end
      rvalid = 1'b1; rid = 8'd0; rresp = 2'b00; rlast = (k == int'(l));
      rdata = mem_rd(int'(b) + 4 * k) ^ ((k == bad_beat) ? 32'h0000_0100 : 32'h0);
      @(negedge aclk);
      rvalid = 1'b0; rlast = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || reject !== 1'b0 || err_cnt !== exp_err || rready !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: done=%b busy=%b reject=%b err_cnt=%0d rready=%b required 1 1 0 %0d 0",
               tag, done, busy, reject, err_cnt, rready, exp_err);
    end
    @(negedge aclk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err_cnt !== exp_err) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b err_cnt=%0d required 0 0 %0d", tag, done, busy, err_cnt, exp_err);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0; start = 1'b0; base_addr = '0; len = '0; seed = '0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    repeat (3) @(negedge aclk);
    checks++;
    if (!outs_quiet() || err_cnt !== 16'd0 || fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: quiet=%b err_cnt=%0d state=%0d required 1 0 0", outs_quiet(), err_cnt, fsm_state);
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_stray();
    bvalid = 1'b1; rvalid = 1'b1; rlast = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      checks++;
      if (bready !== 1'b0 || rready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || fsm_state !== 3'd0) begin
        errors++;
        $display("FAIL stray_resp: bready=%b rready=%b busy=%b done=%b state=%0d required 0 0 0 0 0",
                 bready, rready, busy, done, fsm_state);
      end
    end
    bvalid = 1'b0; rvalid = 1'b0; rlast = 1'b0;
  endtask

  task automatic test_basic();
    run_cmd(16'h0100, 8'd3, 32'hA000_0000, 0, -1, 2'b00, 16'd0, "basic");
    checks++;
    if (mem_rd(16'h0100) !== 32'hA000_0000 || mem_rd(16'h0104) !== 32'hA000_0001 ||
        mem_rd(16'h0108) !== 32'hA000_0002 || mem_rd(16'h010C) !== 32'hA000_0003) begin
      errors++;
      $display("FAIL basic_mem: got %h %h %h %h required a0000000 a0000001 a0000002 a0000003",
               mem_rd(16'h0100), mem_rd(16'h0104), mem_rd(16'h0108), mem_rd(16'h010C));
    end
  endtask

  task automatic test_backpressure();
    run_cmd(16'h0200, 8'd3, 32'h1234_5678, 5, -1, 2'b00, 16'd0, "bp_a");
    run_cmd(16'h0400, 8'd9, 32'h0BAD_F00D, 5, -1, 2'b00, 16'd0, "bp_b");
  endtask

  task automatic test_errors();
    run_cmd(16'h0800, 8'd7, 32'hC0DE_0000, 2, 2, 2'b10, 16'd2, "errors");
  endtask

  task automatic test_reject(input logic [15:0] b, input logic [7:0] l, input string tag);
    @(negedge aclk);
    start = 1'b1; base_addr = b; len = l; seed = 32'h1;
    @(negedge aclk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || reject !== 1'b1 || busy !== 1'b1 || err_cnt !== 16'd0 ||
        awvalid !== 1'b0 || wvalid !== 1'b0 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s reject_fin: done=%b reject=%b busy=%b err_cnt=%0d awv=%b wv=%b arv=%b required 1 1 1 0 0 0 0",
               tag, done, reject, busy, err_cnt, awvalid, wvalid, arvalid);
    end
    @(negedge aclk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || awvalid !== 1'b0 || arvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s reject_idle: done=%b busy=%b awv=%b arv=%b required 0 0 0 0", tag, done, busy, awvalid, arvalid);
    end
  endtask

  task automatic test_boundary();
    // 0x0FF0 + 16 bytes ends exactly on the page edge: accepted
    run_cmd(16'h0FF0, 8'd3, 32'h7777_0000, 1, -1, 2'b00, 16'd0, "page_edge");
  endtask

  task automatic test_wrap();
    run_cmd(16'h2000, 8'd255, 32'hFFFF_FFFE, 0, -1, 2'b00, 16'd0, "wrap");
    checks++;
    if (mem_rd(16'h2004) !== 32'hFFFF_FFFF || mem_rd(16'h2008) !== 32'h0000_0000 ||
        mem_rd(16'h23FC) !== 32'h0000_00FD) begin
      errors++;
      $display("FAIL wrap_mem: got %h %h %h required ffffffff 00000000 000000fd",
               mem_rd(16'h2004), mem_rd(16'h2008), mem_rd(16'h23FC));
    end
  endtask

  task automatic test_reset_mid_burst();
    int done_seen = 0;
    @(negedge aclk);
    start = 1'b1; base_addr = 16'h0300; len = 8'd3; seed = 32'h5555_0000;
    @(negedge aclk);
    start = 1'b0;
    awready = 1'b1;
    @(negedge aclk);
    awready = 1'b0;
    wready = 1'b1;
    @(negedge aclk);
    wready = 1'b0;
    checks++;
    if (fsm_state !== 3'd2 || wvalid !== 1'b1 || wdata !== 32'h5555_0001) begin
      errors++;
      $display("FAIL mid_w_state: state=%0d wvalid=%b wdata=%h required 2 1 55550001", fsm_state, wvalid, wdata);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (!outs_quiet() || err_cnt !== 16'd0 || fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL async_abort: quiet=%b err_cnt=%0d state=%0d required 1 0 0", outs_quiet(), err_cnt, fsm_state);
    end
    repeat (3) begin
      @(negedge aclk);
      if (done) done_seen++;
    end
    aresetn = 1'b1;
    repeat (2) begin
      @(negedge aclk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done_cycles=%0d busy=%b required 0 0", done_seen, busy);
    end
    exp_q.delete();
    run_cmd(16'h0300, 8'd3, 32'h5555_0000, 2, -1, 2'b00, 16'd0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_cmd(16'h0500, 8'd1, 32'h0000_0010, 1, 1, 2'b00, 16'd1, "b2b_a");
    run_cmd(16'h0600, 8'd0, 32'h8000_0000, 0, -1, 2'b00, 16'd0, "b2b_b");
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_stray();
    test_basic();
    test_backpressure();
    test_errors();
    test_reject(16'h0FF8, 8'd3, "cross_4k");
    test_reject(16'h0102, 8'd0, "misaligned");
    test_boundary();
    test_wrap();
    test_reset_mid_burst();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: left=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
